// File: rtl/exec_alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ops register in one cycle, MUL/DIVU/MODU
// iterate one bit per cycle. Results are held under a valid/ready handshake; CMP updates branch flags.
module exec_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero,
  output logic             cond_eq,
  output logic             cond_ge
);

  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VEC    = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LSL  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_MODU = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
  logic                 dz_q, dz_d;
  logic                 cmp_n_q, cmp_n_d, cmp_z_q, cmp_z_d, cmp_v_q, cmp_v_d;

  logic                 accept, sel_iter;
  logic [WIDTH:0]       add_w, shl_w;
  logic [WIDTH-1:0]     sub_w, sc_res;
  logic                 sc_c, sc_v;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   step_work;
  logic [WIDTH-1:0]     fin_res;
  logic                 fin_cv, fin_dz;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign sel_iter  = (sel == OP_MUL) | (sel == OP_DIVU) | (sel == OP_MODU);

  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = A - B;
  // The bit just above the kept word is the last bit shifted out, i.e. A[WIDTH-B].
  assign shl_w = {1'b0, A} << B;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sc_res = sub_w;
        sc_c   = (A >= B);
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_LSL: begin
        sc_res = (B >= W_VEC) ? '0 : shl_w[WIDTH-1:0];
        sc_c   = (B != '0) && (B <= W_VEC) && shl_w[WIDTH];
      end
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: sc_res = A;
      default: sc_res = '0;
    endcase
  end

  // One iteration: shift-add multiply on {acc, multiplier}, restoring divide on {rem, quo}.
  assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = work_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign step_work = (op_q == OP_MUL)
                   ? {mul_sum, work_q[WIDTH-1:1]}
                   : {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};

  assign fin_res = (op_q == OP_MODU) ? step_work[2*WIDTH-1:WIDTH] : step_work[WIDTH-1:0];
  assign fin_cv  = (op_q == OP_MUL) && (step_work[2*WIDTH-1:WIDTH] != '0);
  assign fin_dz  = (op_q != OP_MUL) && (b_q == '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    cmp_n_d = cmp_n_q;
    cmp_z_d = cmp_z_q;
    cmp_v_d = cmp_v_q;

    case (state_q)
      S_BUSY: begin
        work_d = step_work;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          res_d   = fin_res;
          zero_d  = (fin_res == '0);
          neg_d   = fin_res[WIDTH-1];
          carry_d = fin_cv;
          ovf_d   = fin_cv;
          dz_d    = fin_dz;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      op_d  = sel;
      a_d   = A;
      b_d   = B;
      cnt_d = '0;
      if (sel_iter) begin
        state_d = S_BUSY;
        work_d  = {{WIDTH{1'b0}}, ((sel == OP_MUL) ? B : A)};
      end else begin
        state_d = S_DONE;
        res_d   = sc_res;
        zero_d  = (sc_res == '0);
        neg_d   = sc_res[WIDTH-1];
        carry_d = sc_c;
        ovf_d   = sc_v;
        dz_d    = 1'b0;
        if (sel == OP_CMP) begin
          cmp_n_d = sc_res[WIDTH-1];
          cmp_z_d = (sc_res == '0);
          cmp_v_d = sc_v;
        end
      end
    end

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      cmp_n_q <= 1'b0;
      cmp_z_q <= 1'b0;
      cmp_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      cmp_n_q <= cmp_n_d;
      cmp_z_q <= cmp_z_d;
      cmp_v_q <= cmp_v_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign alu_out   = res_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign cond_eq   = cmp_z_q;
  assign cond_ge   = (cmp_n_q == cmp_v_q);

endmodule

// File: tb/tb_exec_alu_mc.sv
// Scoreboard bench for exec_alu_mc: expected results are queued at accept from an arithmetic
// reference model and checked by an independent monitor at each output handshake or stall.
module tb_exec_alu_mc;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_out;
  logic        zero, negative, carry, overflow, div_zero, cond_eq, cond_ge;

  exec_alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .div_zero(div_zero), .cond_eq(cond_eq), .cond_ge(cond_ge)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic z, n, c, v, dz, ce, cg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_pct = 100;
  int   acc_cyc = 0;
  logic m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    exp_t e;
    longint unsigned ua, ub, w;
    longint sa, sb, sw;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    w  = 0;
    sw = 0;
    case (s)
      4'h0: begin
        w = ua + ub; e.res = w[31:0]; e.c = w[32];
        sw = sa + sb; e.v = (sw > MAXS) || (sw < MINS);
      end
      4'h1, 4'h5: begin
        e.res = a - b; e.c = (a >= b);
        sw = sa - sb; e.v = (sw > MAXS) || (sw < MINS);
      end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: begin
        if (ub >= 64'd32) e.res = '0; else e.res = a << b;
        e.c = (ub >= 64'd1 && ub <= 64'd32) ? (((ua >> (64'd32 - ub)) & 64'd1) != 0) : 1'b0;
      end
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: e.res = a;
      4'hC: begin
        w = ua * ub; e.res = w[31:0]; e.c = (w[63:32] != 0); e.v = e.c;
      end
      4'hD: if (b == 0) begin e.res = '1; e.dz = 1'b1; end else e.res = a / b;
      4'hE: if (b == 0) begin e.res = a; e.dz = 1'b1; end else e.res = a % b;
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[31];
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  task automatic nx();
    @(negedge clk);
    out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    exp_t e;
    bit   done;
    done = 1'b0;
    in_valid = 1'b1; A = a; B = b; sel = s;
    for (int k = 0; k < 400 && !done; k++) begin
      #1;
      if (in_ready) begin
        e = model(a, b, s);
        if (s == 4'h5) begin m_n = e.n; m_z = e.z; m_v = e.v; end
        e.ce = m_z;
        e.cg = (m_n == m_v);
        exp_q.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
      end
      nx();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose for sel=%0h", s);
    end
  endtask

  task automatic drain();
    rdy_pct = 100;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) nx();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  // Monitor: compares on each handshake, and checks the held value during back-pressure.
  initial begin : monitor
    exp_t        e;
    logic [38:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        act_v = {alu_out, zero, negative, carry, overflow, div_zero, cond_eq, cond_ge};
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: alu_out=0x%0h with nothing expected", alu_out);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          exp_v = e;
          chk("result", {25'd0, act_v}, {25'd0, exp_v});
        end else begin
          exp_v = exp_q[0];
          chk("stall_hold", {25'd0, act_v}, {25'd0, exp_v});
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  acc[4];
    bit  saw;
    logic [3:0] s;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_out", 64'(alu_out), 64'd0);
    chk("rst_flags", 64'({zero, negative, carry, overflow, div_zero}), 64'd0);
    chk("rst_cond_eq", 64'(cond_eq), 64'd0);
    chk("rst_cond_ge", 64'(cond_ge), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    nx();

    // Directed single-cycle ops, CMP flag persistence and LSL edges.
    rdy_pct = 100;
    issue(32'hFFFF_FFFF, 32'h1, 4'h0);
    chk("sc_latency", 64'(out_valid), 64'd1);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'h1);
    issue(32'd5, 32'd5, 4'h5);
    issue(32'd10, 32'd20, 4'h0);
    issue(32'd3, 32'd7, 4'h5);
    issue(32'd1, 32'd1, 4'h0);
    issue(32'h8000_0001, 32'd0, 4'h4);
    issue(32'h8000_0001, 32'd1, 4'h4);
    issue(32'h8000_0003, 32'd31, 4'h4);
    issue(32'h0000_0001, 32'd32, 4'h4);
    issue(32'hFFFF_FFFF, 32'd33, 4'h4);
    issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'h2);
    issue(32'hF0F0_1234, 32'h0FF0_0000, 4'h3);
    for (int i = 6; i <= 11; i++) issue(32'hA5A5_0000 + 32'(i), 32'd9, 4'(i));
    issue(32'h1234_5678, 32'h9, 4'hF);
    drain();

    // Iterative ops and their latency.
    issue(32'h0001_0000, 32'h0001_0000, 4'hC);
    for (int k = 0; k < 100 && !out_valid; k++) nx();
    chk("mul_latency", 64'(cyc - acc_cyc), 64'd33);
    issue(32'd100, 32'd7, 4'hD);
    issue(32'd100, 32'd7, 4'hE);
    issue(32'd9, 32'd0, 4'hD);
    issue(32'd9, 32'd0, 4'hE);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hC);
    issue(32'hFFFF_FFFF, 32'd1, 4'hD);
    issue(32'h8000_0000, 32'd3, 4'hE);
    drain();

    // Back-pressure then streaming at one op per cycle.
    issue(32'd11, 32'd22, 4'h0);
    rdy_pct = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      nx();
    end
    rdy_pct = 100;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue($urandom(), $urandom(), 4'h0);
      acc[i] = acc_cyc;
    end
    for (int i = 1; i < 4; i++) chk("stream_gap", 64'(acc[i] - acc[i-1]), 64'd1);
    drain();

    // Randomized traffic with random back-pressure.
    rdy_pct = 70;
    for (int n = 0; n < 300; n++) begin
      s = 4'($urandom_range(0, 15));
      if (s == 4'h4) issue(pick(), 32'($urandom_range(0, 40)), s);
      else issue(pick(), pick(), s);
      if ($urandom_range(0, 4) == 0) nx();
    end
    drain();

    // Flush in BUSY.
    issue(32'd123, 32'd45, 4'hC);
    repeat (5) nx();
    #1;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    nx();
    flush = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("flush_busy_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy_in_ready", 64'(in_ready), 64'd1);
    saw = 1'b0;
    repeat (40) begin
      nx();
      if (out_valid) saw = 1'b1;
    end
    chk("flush_busy_no_result", 64'(saw), 64'd0);

    // Flush while holding a result.
    issue(32'd3, 32'd7, 4'h5);
    drain();
    rdy_pct = 0;
    issue(32'd2, 32'd3, 4'h0);
    flush = 1'b1;
    nx();
    flush = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);

    // Flush in IDLE drops a CMP: branch flags must stay from CMP 3,7.
    rdy_pct = 100;
    nx();
    in_valid = 1'b1; A = 32'd5; B = 32'd5; sel = 4'h5; flush = 1'b1;
    nx();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_drop_out_valid", 64'(out_valid), 64'd0);
    issue(32'd4, 32'd4, 4'h0);
    drain();

    // Asynchronous reset in the middle of an iterative op.
    issue(32'd3, 32'd7, 4'h5);
    issue(32'd77, 32'd3, 4'hC);
    repeat (4) nx();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_alu_out", 64'(alu_out), 64'd0);
    chk("midrst_flags", 64'({zero, negative, carry, overflow, div_zero}), 64'd0);
    chk("midrst_cond_eq", 64'(cond_eq), 64'd0);
    chk("midrst_cond_ge", 64'(cond_ge), 64'd1);
    exp_q.delete();
    m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    nx();
    nx();
    rst_n = 1'b1;
    nx();
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    issue(32'd0, 32'd0, 4'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_alu_mc.md
# exec_alu_mc

Parametrised multi-cycle execute-stage ALU for the pipelined core. It keeps the existing 4-bit opcode map and adds an iterative multiply/divide unit, a registered result with valid/ready handshakes, a full NZCV flag set, and a persistent CMP flag register that drives the branch conditions BEQ and BGE. It sits between the decode/register-read stage and the memory/writeback stage.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  operands and sel are valid.
- in_ready  out  1  the block can accept an op this cycle.
- A, B  in  WIDTH each  operands.
- sel  in  4  opcode.
- out_valid  out  1  result is held valid.
- out_ready  in  1  downstream accepts the result.
- alu_out  out  WIDTH  registered result.
- zero, negative, carry, overflow  out  1 each  flags of alu_out.
- div_zero  out  1  the current result came from a divide or modulo by zero.
- cond_eq, cond_ge  out  1 each  branch conditions from the CMP flag register.

## Operation
- Opcodes: 0000 ADD; 0001 SUB; 0010 bitwise AND; 0011 bitwise OR; 0100 LSL (A << B); 0101 CMP (A−B); 0110–1011 pass A (SET, LDR, STR, B, BEQ, BGE).
- Iterative opcodes: 1100 MUL (low WIDTH bits of the product); 1101 DIVU (unsigned quotient); 1110 MODU (unsigned remainder).
- Any other sel (0111 is already pass-A; 1111 is NOP): alu_out is 0, zero is 1, and all other flags are 0.
- Flags are computed from the final result:
  - zero = (alu_out == 0); negative = alu_out[WIDTH−1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB/CMP: carry = A ≥ B unsigned (no-borrow); overflow = signed overflow.
  - LSL: for B in 1..WIDTH, carry = A[WIDTH−B]; otherwise carry = 0. If B ≥ WIDTH, the result is 0. overflow = 0.
  - MUL: carry = overflow = 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - Logic, pass and DIV ops: carry = overflow = 0.
- Divide by zero (B = 0): DIVU returns all ones, MODU returns A, and div_zero = 1. The op still takes the full iterative latency.
- flags_q {N, Z, C, V} is updated only when a CMP result enters DONE.
  - cond_eq = flags_q.Z.
  - cond_ge = (flags_q.N == flags_q.V).
- FSM states:
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → BUSY on accepting an iterative op.
  - BUSY → DONE after WIDTH iterations (one bit per cycle: shift-add for MUL, restoring division for DIV/MOD).
  - DONE → IDLE on out_valid & out_ready with no new accept.
  - DONE → DONE/BUSY on out_valid & out_ready with a simultaneous accept.
- in_ready = (state == IDLE) | (state == DONE & out_ready). in_ready is combinational from out_ready.
- Operands and sel are captured at accept. Changes on A, B or sel after accept have no effect.
- flush has priority over everything except reset. The next state is IDLE, out_valid is 0 the next cycle, and any accept in the flush cycle is dropped. flags_q and cond_* are not changed.

## Timing
- Reset values: state IDLE, out_valid 0, alu_out 0, all result flags 0, div_zero 0, flags_q 0.
  - Hence cond_eq = 0 and cond_ge = 1 after reset.
  - in_ready is 1 once rst_n deasserts.
- Single-cycle op: accepted at edge t, out_valid = 1 after edge t+1 (latency 1).
- Iterative op: accepted at edge t, out_valid = 1 after edge t+WIDTH+1. in_ready = 0 during BUSY.
- Back-pressure: while out_valid & !out_ready, alu_out, the flags and div_zero stay stable and in_ready = 0.
- Throughput: one single-cycle op per cycle while out_ready = 1.
- cond_eq and cond_ge change on the same edge as out_valid rises for a CMP.
- Reset asserted mid-BUSY or mid-DONE returns all registers to their reset values immediately (asynchronously).

## Test plan
- WIDTH = 32; ADD with A = 0xFFFFFFFF, B = 1 → one cycle later alu_out = 0, zero = 1, carry = 1, overflow = 0.
- SUB with A = 0x7FFFFFFF, B = 0xFFFFFFFF → alu_out = 0x80000000, negative = 1, overflow = 1, carry = 0.
- CMP 5,5 then CMP 3,7 → after the first, cond_eq = 1 and cond_ge = 1; after the second, cond_eq = 0 and cond_ge = 0.
  - An ADD issued between them leaves the cond outputs unchanged.
- MUL 0x10000 × 0x10000 → out_valid exactly 33 cycles after accept, alu_out = 0, carry = 1.
- DIVU 100/7 → 14; MODU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF with div_zero = 1.
- Hold out_ready = 0 for 3 cycles, then stream 4 ADDs with out_ready = 1 → the result is stable during the stall, then one result per cycle.
- Flush in mid-BUSY → out_valid stays 0 and in_ready = 1 the next cycle.
- Deassert rst_n mid-BUSY → all outputs return to their reset values.
